// File: rtl/complex_pkg.sv
// Shared definitions for the complex multiplier datapath.
// Holds the operand loader state encodings, the word slots of a frame and the default width.
package complex_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Loader FSM states
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } loader_state_e;

    // Position of each component word inside a frame
    localparam logic [1:0] W_A_RE = 2'd0;
    localparam logic [1:0] W_A_IM = 2'd1;
    localparam logic [1:0] W_B_RE = 2'd2;
    localparam logic [1:0] W_B_IM = 2'd3;

endpackage

// File: rtl/operand_loader.sv
// Operand loader: packs a four-word stream (re_a, im_a, re_b, im_b) into one complex operand pair.
// It buffers a single pair and offers it downstream with op_val/op_ready.
// A word that breaks framing raises a one-cycle frame_err pulse. The loader then realigns on in_sop.
module operand_loader
    import complex_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  sw_rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_val,
    input  logic                  in_sop,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] op_a_re,
    output logic [DATA_WIDTH-1:0] op_a_im,
    output logic [DATA_WIDTH-1:0] op_b_re,
    output logic [DATA_WIDTH-1:0] op_b_im,
    output logic                  op_val,
    input  logic                  op_ready,
    output logic                  frame_err
);

    loader_state_e         state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] a_re_q, a_re_d;
    logic [DATA_WIDTH-1:0] a_im_q, a_im_d;
    logic [DATA_WIDTH-1:0] b_re_q, b_re_d;
    logic [DATA_WIDTH-1:0] b_im_q, b_im_d;
    logic                  accept;

    assign accept = in_val & in_ready;

    // State, word counter, error pulse and operand registers
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q <= COLLECT;
            cnt_q   <= W_A_RE;
            err_q   <= 1'b0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            b_re_q  <= b_re_d;
            b_im_q  <= b_im_d;
        end
    end

    // Next state: steer accepted words into their slot, detect framing faults, release on transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        b_re_d  = b_re_q;
        b_im_d  = b_im_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (in_sop) begin
                        // sop always starts a new frame; mid-frame it also abandons the partial one
                        a_re_d = in_data;
                        cnt_d  = W_A_IM;
                        err_d  = (cnt_q != W_A_RE);
                    end else begin
                        case (cnt_q)
                            W_A_RE: err_d = 1'b1;  // word without sop cannot start a frame: drop it
                            W_A_IM: begin
                                a_im_d = in_data;
                                cnt_d  = W_B_RE;
                            end
                            W_B_RE: begin
                                b_re_d = in_data;
                                cnt_d  = W_B_IM;
                            end
                            default: begin
                                b_im_d  = in_data;
                                cnt_d   = W_A_RE;
                                state_d = HOLD;
                            end
                        endcase
                    end
                end
            end
            default: begin
                if (op_ready) begin
                    state_d = COLLECT;
                end
            end
        endcase
    end

    // Outputs: handshake flags follow the state, operands come straight from the registers
    always_comb begin
        in_ready  = (state_q == COLLECT);
        op_val    = (state_q == HOLD);
        frame_err = err_q;
        op_a_re   = a_re_q;
        op_a_im   = a_im_q;
        op_b_re   = b_re_q;
        op_b_im   = b_im_q;
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader at DATA_WIDTH=8.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       sw_rst;
    logic [7:0] in_data;
    logic       in_val;
    logic       in_sop;
    logic       in_ready;
    logic [7:0] op_a_re, op_a_im, op_b_re, op_b_im;
    logic       op_val;
    logic       op_ready;
    logic       frame_err;

    int n_cmp  = 0;
    int n_fail = 0;

    operand_loader #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .sw_rst    (sw_rst),
        .in_data   (in_data),
        .in_val    (in_val),
        .in_sop    (in_sop),
        .in_ready  (in_ready),
        .op_a_re   (op_a_re),
        .op_a_im   (op_a_im),
        .op_b_re   (op_b_re),
        .op_b_im   (op_b_im),
        .op_val    (op_val),
        .op_ready  (op_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ops(input string tag, input logic [7:0] ar, input logic [7:0] ai,
                           input logic [7:0] br, input logic [7:0] bi);
        chk({tag, ".a_re"}, {24'd0, op_a_re}, {24'd0, ar});
        chk({tag, ".a_im"}, {24'd0, op_a_im}, {24'd0, ai});
        chk({tag, ".b_re"}, {24'd0, op_b_re}, {24'd0, br});
        chk({tag, ".b_im"}, {24'd0, op_b_im}, {24'd0, bi});
    endtask

    task automatic chk_flags(input string tag, input logic rdy, input logic vld, input logic err);
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
        chk({tag, ".op_val"},    {31'd0, op_val},    {31'd0, vld});
        chk({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, err});
    endtask

    // One word presented for exactly one clock edge
    task automatic send(input logic [7:0] d, input logic sop);
        in_val  = 1'b1;
        in_data = d;
        in_sop  = sop;
        tick();
        in_val  = 1'b0;
        in_sop  = 1'b0;
    endtask

    initial begin
        sw_rst   = 1'b1;
        in_data  = 8'h00;
        in_val   = 1'b0;
        in_sop   = 1'b0;
        op_ready = 1'b1;

        // 1 Reset
        tick();
        tick();
        sw_rst = 1'b0;
        chk_flags("reset", 1'b1, 1'b0, 1'b0);
        chk_ops("reset", 8'h00, 8'h00, 8'h00, 8'h00);

        // 2 Nominal frame with op_ready high
        send(8'h03, 1'b1);
        chk_flags("nom.w1", 1'b1, 1'b0, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        chk("nom.w3.op_val", {31'd0, op_val}, 32'd0);
        send(8'hFA, 1'b0);
        chk_flags("nom.hold", 1'b0, 1'b1, 1'b0);
        chk_ops("nom", 8'h03, 8'h04, 8'h05, 8'hFA);
        tick();
        chk_flags("nom.xfer", 1'b1, 1'b0, 1'b0);

        // 3 Backpressure: pair held for 10 cycles, stray in_val ignored
        op_ready = 1'b0;
        send(8'h10, 1'b1);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_val  = 1'b1;
            in_data = 8'hFF;
            in_sop  = i[0];
            tick();
            chk_flags("bp.hold", 1'b0, 1'b1, 1'b0);
            chk_ops("bp.hold", 8'h10, 8'h20, 8'h30, 8'h40);
        end
        in_val   = 1'b0;
        in_sop   = 1'b0;
        op_ready = 1'b1;
        tick();
        chk_flags("bp.xfer", 1'b1, 1'b0, 1'b0);
        tick();
        chk_flags("bp.idle", 1'b1, 1'b0, 1'b0);

        // 4 Missing sop: word dropped, error pulse, then a clean frame
        send(8'h11, 1'b0);
        chk_flags("nosop.err", 1'b1, 1'b0, 1'b1);
        chk("nosop.dropped", {24'd0, op_a_re}, 32'h10);
        tick();
        chk("nosop.pulse_end", {31'd0, frame_err}, 32'd0);
        send(8'h21, 1'b1);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b0);
        chk_flags("nosop.hold", 1'b0, 1'b1, 1'b0);
        chk_ops("nosop", 8'h21, 8'h22, 8'h23, 8'h24);
        tick();
        chk_flags("nosop.xfer", 1'b1, 1'b0, 1'b0);

        // 5 Early sop restarts the frame
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        chk("early.w2.err", {31'd0, frame_err}, 32'd0);
        send(8'h09, 1'b1);
        chk_flags("early.err", 1'b1, 1'b0, 1'b1);
        send(8'h0A, 1'b0);
        chk("early.pulse_end", {31'd0, frame_err}, 32'd0);
        send(8'h0B, 1'b0);
        chk("early.w5.op_val", {31'd0, op_val}, 32'd0);
        send(8'h0C, 1'b0);
        chk_flags("early.hold", 1'b0, 1'b1, 1'b0);
        chk_ops("early", 8'h09, 8'h0A, 8'h0B, 8'h0C);
        tick();
        chk_flags("early.xfer", 1'b1, 1'b0, 1'b0);

        // 6a Reset after two words
        send(8'h55, 1'b1);
        send(8'h66, 1'b0);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk_flags("rst_mid", 1'b1, 1'b0, 1'b0);
        chk_ops("rst_mid", 8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h71, 1'b1);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        send(8'h74, 1'b0);
        chk_ops("rst_mid.next", 8'h71, 8'h72, 8'h73, 8'h74);
        chk("rst_mid.next.op_val", {31'd0, op_val}, 32'd1);
        tick();

        // 6b Reset while holding a pair
        op_ready = 1'b0;
        send(8'h81, 1'b1);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b0);
        chk("rst_hold.pre.op_val", {31'd0, op_val}, 32'd1);
        sw_rst   = 1'b1;
        op_ready = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk_flags("rst_hold", 1'b1, 1'b0, 1'b0);
        chk_ops("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00);
        send(8'h91, 1'b1);
        send(8'h92, 1'b0);
        send(8'h93, 1'b0);
        send(8'h94, 1'b0);
        chk_flags("rst_hold.next", 1'b0, 1'b1, 1'b0);
        chk_ops("rst_hold.next", 8'h91, 8'h92, 8'h93, 8'h94);
        tick();
        chk_flags("rst_hold.xfer", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
